// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx_in, samples each bit at mid-bit and writes
// each good byte to the downstream FIFO with a one-cycle wrreq strobe.
module uart_rx #(
  parameter int unsigned BAUD_RATE      = 1382400,
  parameter int unsigned CLK_FREQURENCE = 12000000
) (
  input  logic       sysclk_12,
  input  logic       i_rest,
  input  logic       rx_in,
  input  logic       wrfull,
  output logic [7:0] paralle_data,
  output logic       wrreq,
  output logic       frame_err,
  output logic       overrun,
  output logic       recv_sta_flg
);

  localparam int unsigned BIT_CNT  = CLK_FREQURENCE / BAUD_RATE;
  localparam int unsigned HALF_CNT = BIT_CNT / 2;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned BCNT_W   = 3;
  localparam int unsigned DATA_W   = 8;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    clk_cnt, clk_cnt_next;
  logic [BCNT_W-1:0]   bit_cnt, bit_cnt_next;
  logic [DATA_W-1:0]   shift, shift_next;
  logic [DATA_W-1:0]   data_next;
  logic                wrreq_next, frame_err_next, overrun_next, sta_next;
  logic                rx_s1, rx_s2, rx_d;
  logic                primed, armed;

  // Synchroniser and edge history. armed only sets once the line has really
  // been seen high, so a line held low out of reset never fakes a start edge.
  always_ff @(posedge sysclk_12 or posedge i_rest) begin
    if (i_rest) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_d   <= 1'b1;
      primed <= 1'b0;
      armed  <= 1'b0;
    end else begin
      rx_s1  <= rx_in;
      rx_s2  <= rx_s1;
      rx_d   <= rx_s2;
      primed <= 1'b1;
      armed  <= armed | (primed & rx_s1);
    end
  end

  always_ff @(posedge sysclk_12 or posedge i_rest) begin
    if (i_rest) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    clk_cnt_next   = clk_cnt + CNT_W'(1);
    bit_cnt_next   = bit_cnt;
    shift_next     = shift;
    data_next      = paralle_data;
    wrreq_next     = 1'b0;
    frame_err_next = 1'b0;
    overrun_next   = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_next = '0;
        bit_cnt_next = '0;
        if (armed && rx_d && !rx_s2) state_next = START;
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_next = '0;
          state_next   = rx_s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          shift_next   = {rx_s2, shift[DATA_W-1:1]};
          bit_cnt_next = bit_cnt + BCNT_W'(1);
          if (bit_cnt == BCNT_W'(7)) state_next = STOP;
        end
      end
      STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is still caught.
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          state_next   = IDLE;
          if (!rx_s2)       frame_err_next = 1'b1;
          else if (wrfull)  overrun_next   = 1'b1;
          else begin
            wrreq_next = 1'b1;
            data_next  = shift;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        clk_cnt_next = '0;
      end
    endcase
    sta_next = (state_next != IDLE);
  end

  always_ff @(posedge sysclk_12 or posedge i_rest) begin
    if (i_rest) begin
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      paralle_data <= '0;
      wrreq        <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      recv_sta_flg <= 1'b0;
    end else begin
      clk_cnt      <= clk_cnt_next;
      bit_cnt      <= bit_cnt_next;
      shift        <= shift_next;
      paralle_data <= data_next;
      wrreq        <= wrreq_next;
      frame_err    <= frame_err_next;
      overrun      <= overrun_next;
      recv_sta_flg <= sta_next;
    end
  end

endmodule
